// File: rtl/potential_accumulator_array_if.sv
// potential_accumulator_array_if
//   Handshake bundle between the weight stream, the potential engine and the
//   spike packetiser.
//   Weight port : in_valid, in_ready, in_idx, in_weight (master -> slave)
//   Spike port  : spike_valid, spike_idx (slave -> master), spike_ready (master -> slave)
//   master = traffic source/sink side, slave = potential_accumulator_array.
interface potential_accumulator_array_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        in_idx;
  logic signed [WIDTH-1:0] in_weight;
  logic                    spike_valid;
  logic                    spike_ready;
  logic [IDX_W-1:0]        spike_idx;

  modport master (
    output in_valid, in_idx, in_weight, spike_ready,
    input  in_ready, spike_valid, spike_idx
  );

  modport slave (
    input  in_valid, in_idx, in_weight, spike_ready,
    output in_ready, spike_valid, spike_idx
  );
endinterface

// File: rtl/potential_accumulator_array.sv
// potential_accumulator_array
//   Time-multiplexed membrane-potential engine for NEURONS integrate-and-fire
//   neurons. Weights accumulate into per-neuron potentials while in ACCUM; a
//   step pulse starts a scan that evaluates one neuron per cycle (refractory
//   hold, threshold fire with spike handshake, or shift-based leak).
// Ports
//   clk, reset     : clock (rising edge), synchronous active-high reset
//   reset_mode     : 0 = subtract threshold on spike, 1 = reset to zero
//   decay_shift    : leak shift amount, 0 disables leak
//   v_threshold    : signed threshold, captured when a step is accepted
//   step           : one-cycle pulse ending the timestep
//   step_done      : one-cycle pulse when the scan completes
//   step_overrun   : one-cycle pulse (cycle after) when step arrives outside ACCUM
//   bus            : weight input and spike output handshakes (slave side)
module potential_accumulator_array #(
  parameter int NEURONS = 8,
  parameter int WIDTH   = 16,
  parameter int IDX_W   = $clog2(NEURONS),
  parameter int REFRACT = 2,
  parameter int REFR_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_mode,
  input  logic [3:0]              decay_shift,
  input  logic signed [WIDTH-1:0] v_threshold,
  input  logic                    step,
  output logic                    step_done,
  output logic                    step_overrun,
  potential_accumulator_array_if.slave bus
);

  // Storage address width; in_idx may be wider so out-of-range indices exist.
  localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Saturate a WIDTH+1 bit signed result back into WIDTH bits.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1]) begin
      sat = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat = x[WIDTH-1:0];
    end
  endfunction

  // Sign-extend a WIDTH bit value by one bit.
  function automatic logic signed [WIDTH:0] ext(input logic signed [WIDTH-1:0] a);
    ext = {a[WIDTH-1], a};
  endfunction

  state_t                  state_r;
  state_t                  state_nxt;
  logic signed [WIDTH-1:0] pot_r  [NEURONS];
  logic [REFR_W-1:0]       refr_r [NEURONS];
  logic signed [WIDTH-1:0] thr_r;
  logic [AW-1:0]           ptr_r;

  logic [AW-1:0]           in_idx_s;
  logic                    in_range_s;
  logic                    acc_en_s;
  logic signed [WIDTH-1:0] acc_sum_s;
  logic signed [WIDTH-1:0] cur_pot_s;
  logic [REFR_W-1:0]       cur_refr_s;
  logic                    in_refr_s;
  logic                    fire_s;
  logic                    last_s;
  logic                    advance_s;
  logic signed [WIDTH-1:0] leak_s;
  logic signed [WIDTH-1:0] new_pot_s;
  logic [REFR_W-1:0]       new_refr_s;

  // Weight path: range/refractory gating and saturated accumulate.
  always_comb begin
    in_idx_s   = bus.in_idx[AW-1:0];
    // Extra leading zero keeps the compare correct when NEURONS == 2**IDX_W.
    in_range_s = ({1'b0, bus.in_idx} < (IDX_W+1)'(NEURONS));
    acc_sum_s  = sat(ext(pot_r[in_idx_s]) + ext(bus.in_weight));
    if (bus.in_valid && (state_r == ST_ACCUM) && in_range_s &&
        (refr_r[in_idx_s] == {REFR_W{1'b0}})) begin
      acc_en_s = 1'b1;
    end else begin
      acc_en_s = 1'b0;
    end
  end

  // Scan path: evaluate the neuron at ptr_r and form its update.
  always_comb begin
    cur_pot_s  = pot_r[ptr_r];
    cur_refr_s = refr_r[ptr_r];
    in_refr_s  = (cur_refr_s != {REFR_W{1'b0}});
    // Refractory takes precedence over firing.
    fire_s     = !in_refr_s && (cur_pot_s >= thr_r);
    last_s     = (ptr_r == AW'(NEURONS - 1));
    // A zero shift would compute v - v; leak is disabled instead.
    if (decay_shift == 4'd0) begin
      leak_s = cur_pot_s;
    end else begin
      leak_s = sat(ext(cur_pot_s) - ext(cur_pot_s >>> decay_shift));
    end
    if (in_refr_s) begin
      new_pot_s  = {WIDTH{1'b0}};
      new_refr_s = cur_refr_s - {{(REFR_W-1){1'b0}}, 1'b1};
    end else if (fire_s) begin
      new_pot_s  = reset_mode ? {WIDTH{1'b0}} : sat(ext(cur_pot_s) - ext(thr_r));
      new_refr_s = REFR_W'(REFRACT);
    end else begin
      new_pot_s  = leak_s;
      new_refr_s = cur_refr_s;
    end
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_nxt       = state_r;
    bus.in_ready    = 1'b0;
    bus.spike_valid = 1'b0;
    bus.spike_idx   = {IDX_W{1'b0}};
    step_done       = 1'b0;
    advance_s       = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        if (step) begin
          state_nxt = ST_SCAN;
        end else begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_SCAN: begin
        if (fire_s) begin
          bus.spike_valid = 1'b1;
          bus.spike_idx   = IDX_W'(ptr_r);
          advance_s       = bus.spike_ready;
        end else begin
          advance_s = 1'b1;
        end
        if (advance_s && last_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        step_done = 1'b1;
        state_nxt = ST_ACCUM;
      end
      default: begin
        state_nxt = ST_ACCUM;
      end
    endcase
  end

  // State register, potential/refractory storage and scan pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_ACCUM;
      thr_r        <= {WIDTH{1'b0}};
      ptr_r        <= {AW{1'b0}};
      step_overrun <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        pot_r[i]  <= {WIDTH{1'b0}};
        refr_r[i] <= {REFR_W{1'b0}};
      end
    end else begin
      state_r      <= state_nxt;
      step_overrun <= step && (state_r != ST_ACCUM);
      // A weight taken alongside step lands before the scan reads pot_r.
      if (acc_en_s) begin
        pot_r[in_idx_s] <= acc_sum_s;
      end
      if ((state_r == ST_ACCUM) && step) begin
        thr_r <= v_threshold;
        ptr_r <= {AW{1'b0}};
      end else if (advance_s) begin
        pot_r[ptr_r]  <= new_pot_s;
        refr_r[ptr_r] <= new_refr_s;
        ptr_r         <= last_s ? {AW{1'b0}} : ptr_r + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_potential_accumulator_array.sv
// Directed bench for potential_accumulator_array (NEURONS=8, WIDTH=16).
// IDX_W is widened to 4 so that an out-of-range index (8) can be driven.
module tb_potential_accumulator_array;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               reset_mode = 1'b0;
  logic [3:0]         decay_shift = 4'd0;
  logic signed [15:0] v_threshold = 16'sd0;
  logic               step = 1'b0;
  logic               step_done;
  logic               step_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int done_lat;
  int spk_q[$];

  potential_accumulator_array_if #(.WIDTH(16), .IDX_W(4)) bus ();

  potential_accumulator_array #(
    .NEURONS(8), .WIDTH(16), .IDX_W(4), .REFRACT(2), .REFR_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reset_mode  (reset_mode),
    .decay_shift (decay_shift),
    .v_threshold (v_threshold),
    .step        (step),
    .step_done   (step_done),
    .step_overrun(step_overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_weight(input int idx, input int w);
    bus.in_valid  = 1'b1;
    bus.in_idx    = 4'(idx);
    bus.in_weight = 16'(w);
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Pulse step and run the scan to step_done. The first `hold` cycles with a
  // spike pending are stalled (spike_idx must equal stall_idx); a second step
  // is injected at scan cycle ovr_cyc when ovr_cyc > 0.
  task automatic run_step(input int hold, input int stall_idx, input int ovr_cyc);
    int cyc;
    int stall;
    cyc = 0;
    stall = 0;
    done_lat = -1;
    spk_q.delete();
    step = 1'b1;
    while (done_lat < 0 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) step = 1'b0;
      if (ovr_cyc > 0 && cyc == ovr_cyc) step = 1'b1;
      if (ovr_cyc > 0 && cyc == ovr_cyc + 1) begin
        step = 1'b0;
        check("overrun_pulse", int'(step_overrun), 1);
      end
      if (ovr_cyc > 0 && cyc == ovr_cyc + 2) check("overrun_clear", int'(step_overrun), 0);
      if (step_done) begin
        done_lat = cyc;
      end else if (bus.spike_valid) begin
        if (stall < hold) begin
          bus.spike_ready = 1'b0;
          check("stall_idx", int'(bus.spike_idx), stall_idx);
          stall++;
        end else begin
          bus.spike_ready = 1'b1;
          spk_q.push_back(int'(bus.spike_idx));
        end
      end
    end
    bus.spike_ready = 1'b1;
    if (done_lat < 0) check("scan_timeout", 0, 1);
    check("in_ready_done", int'(bus.in_ready), 0);
    tick();
    check("in_ready_back", int'(bus.in_ready), 1);
  endtask

  task automatic expect_spikes(input string tag, input int n, input int a, input int b);
    check({tag, "_count"}, spk_q.size(), n);
    if (n > 0 && spk_q.size() > 0) check({tag, "_idx0"}, spk_q[0], a);
    if (n > 1 && spk_q.size() > 1) check({tag, "_idx1"}, spk_q[1], b);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_idx      = 4'd0;
    bus.in_weight   = 16'sd0;
    bus.spike_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_spike_valid", int'(bus.spike_valid), 0);
    check("rst_spike_idx", int'(bus.spike_idx), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_overrun", int'(step_overrun), 0);

    // Accumulate and fire, subtract mode
    reset_mode = 1'b0; v_threshold = 16'sd100; decay_shift = 4'd0;
    send_weight(3, 60);
    check("acc_lat", int'(dut.pot_r[3]), 60);
    send_weight(3, 50);
    check("acc_sum", int'(dut.pot_r[3]), 110);
    run_step(0, 0, 0);
    expect_spikes("sub", 1, 3, 0);
    check("sub_done_lat", done_lat, 9);
    check("sub_pot3", int'(dut.pot_r[3]), 10);

    // Reset-to-zero and refractory
    do_reset();
    reset_mode = 1'b1;
    send_weight(0, 120);
    run_step(0, 0, 0);
    expect_spikes("rz", 1, 0, 0);
    check("rz_pot0", int'(dut.pot_r[0]), 0);
    send_weight(0, 200);
    check("refr_discard1", int'(dut.pot_r[0]), 0);
    run_step(0, 0, 0);
    expect_spikes("refr1", 0, 0, 0);
    send_weight(0, 200);
    check("refr_discard2", int'(dut.pot_r[0]), 0);
    run_step(0, 0, 0);
    expect_spikes("refr2", 0, 0, 0);
    send_weight(0, 200);
    check("refr_accept", int'(dut.pot_r[0]), 200);
    run_step(0, 0, 0);
    expect_spikes("refr3", 1, 0, 0);

    // Leak
    do_reset();
    reset_mode = 1'b0; v_threshold = 16'sd1000; decay_shift = 4'd2;
    send_weight(5, 64);
    send_weight(2, -64);
    run_step(0, 0, 0);
    check("leak_pos1", int'(dut.pot_r[5]), 48);
    check("leak_neg", int'(dut.pot_r[2]), -48);
    run_step(0, 0, 0);
    check("leak_pos2", int'(dut.pot_r[5]), 36);
    expect_spikes("leak", 0, 0, 0);

    // Backpressure
    do_reset();
    v_threshold = 16'sd100; decay_shift = 4'd0;
    send_weight(1, 150);
    send_weight(6, 200);
    run_step(5, 1, 0);
    expect_spikes("bp", 2, 1, 6);
    check("bp_done_lat", done_lat, 14);
    check("bp_pot1", int'(dut.pot_r[1]), 50);
    check("bp_pot6", int'(dut.pot_r[6]), 100);

    // Saturation and bounds
    do_reset();
    send_weight(4, 32760);
    send_weight(4, 100);
    check("sat_pos", int'(dut.pot_r[4]), 32767);
    send_weight(7, -32760);
    send_weight(7, -100);
    check("sat_neg", int'(dut.pot_r[7]), -32768);
    send_weight(8, 500);
    check("oob_pot0", int'(dut.pot_r[0]), 0);
    check("oob_pot4", int'(dut.pot_r[4]), 32767);

    // Overrun during scan
    do_reset();
    v_threshold = 16'sd100;
    send_weight(2, 150);
    run_step(0, 0, 1);
    expect_spikes("ovr", 1, 2, 0);
    check("ovr_done_lat", done_lat, 9);
    check("ovr_pot2", int'(dut.pot_r[2]), 50);

    // Reset during a spike stall
    send_weight(4, 150);
    step = 1'b1;
    tick();
    step = 1'b0;
    bus.spike_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.spike_valid) break;
    end
    check("stall_valid", int'(bus.spike_valid), 1);
    check("stall_idx4", int'(bus.spike_idx), 4);
    tick();
    check("stall_hold", int'(bus.spike_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", int'(bus.spike_valid), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_pot4", int'(dut.pot_r[4]), 0);
    check("mid_rst_pot2", int'(dut.pot_r[2]), 0);
    bus.spike_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/potential_accumulator_array.md
# potential_accumulator_array

Time-multiplexed membrane-potential engine for `NEURONS` integrate-and-fire neurons, the parametrised successor of the single-neuron potential adder. It accumulates signed fixed-point synaptic weights into per-neuron potentials during a timestep. On a step command it scans every neuron once:

- threshold compare;
- spike emission over a valid/ready port;
- reset by subtraction or to zero;
- refractory hold;
- shift-based leak decay.

It sits between the network-interface weight stream and the spike packetiser.

## Interface
Parameters:
- `NEURONS`, 8: number of neurons, ≥2.
- `WIDTH`, 16: signed two's-complement potential/weight width.
- `IDX_W`, `$clog2(NEURONS)`: neuron index width.
- `REFRACT`, 2: refractory timesteps after a spike (0 = none).
- `REFR_W`, 4: refractory counter width; `REFRACT < 2**REFR_W`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `reset_mode` in 1: 0 = subtract threshold on spike, 1 = reset to zero.
- `decay_shift` in 4: leak shift amount; 0 disables leak.
- `v_threshold` in `WIDTH`: signed threshold, sampled on step acceptance.
- `in_valid` in 1: weight present.
- `in_ready` out 1: weight accepted when `in_valid & in_ready`.
- `in_idx` in `IDX_W`: target neuron.
- `in_weight` in `WIDTH`: signed weight.
- `step` in 1: one-cycle pulse ending the timestep.
- `spike_valid` out 1: spike present.
- `spike_ready` in 1: downstream accepts spike.
- `spike_idx` out `IDX_W`: spiking neuron.
- `step_done` out 1: one-cycle pulse, scan complete.
- `step_overrun` out 1: one-cycle pulse, `step` seen while not in ACCUM.

## Operation
- Storage: `pot[NEURONS]` (`WIDTH`, signed), `refr[NEURONS]` (`REFR_W`), `thr_q` (`WIDTH`), scan pointer `ptr`.
- All arithmetic is signed, computed at `WIDTH+1` bits, saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- FSM states: ACCUM, SCAN, DONE.
- **ACCUM**
  - `in_ready=1`.
  - On handshake, `pot[in_idx] <= sat(pot[in_idx] + in_weight)`.
  - A weight is accepted but discarded if `in_idx ≥ NEURONS` or `refr[in_idx] != 0`.
  - On `step`: `thr_q <= v_threshold`, `ptr <= 0`, go to SCAN.
  - A weight handshaken in the same cycle as `step` is applied before the scan.
- **SCAN** (`in_ready=0`). One neuron is evaluated per cycle at `ptr`, with `v = pot[ptr]`:
  - **Refractory** (`refr[ptr] != 0`): `refr--`; `pot <= 0`; no spike; advance.
  - **Fire** (`v ≥ thr_q`):
    - Drive `spike_valid=1`, `spike_idx=ptr`.
    - Stall with `ptr`, `pot` and `refr` unchanged until `spike_ready`.
    - On handshake: `pot <= (reset_mode ? 0 : sat(v − thr_q))`, `refr <= REFRACT`, advance.
  - **Leak** (otherwise): `pot <= v − (v >>> decay_shift)`, using an arithmetic shift; advance. With `decay_shift=0` the potential is unchanged.
  - Advance from `ptr = NEURONS−1` goes to DONE.
- **DONE**: `step_done=1` for one cycle, then ACCUM.
- `step` outside ACCUM is ignored; it pulses `step_overrun` for one cycle.
- `spike_valid` and `spike_idx` are stable while stalled. `spike_valid` never drops without a handshake except on `reset`.

## Timing
- **Reset** (synchronous, any state, including mid-scan stall):
  - All `pot` and `refr` cleared to 0, `thr_q=0`, state ACCUM.
  - Outputs: `in_ready=1` from the first cycle after reset deasserts; `spike_valid=0`, `spike_idx=0`, `step_done=0`, `step_overrun=0`.
  - A pending spike is dropped.
- Weight latency: an accepted weight is visible in `pot` on the next cycle.
- A scan with no stalls takes `NEURONS` cycles in SCAN plus 1 in DONE. `step_done` asserts `NEURONS+1` cycles after the step edge; `in_ready` returns the following cycle.
- Each stalled spike adds one cycle per cycle that `spike_ready` is low.
- `spike_valid` asserts combinationally off the registered `ptr`/`pot` in the SCAN cycle evaluating the neuron.

## Test plan
- **Accumulate and fire, subtract mode.** `reset_mode=0`, `thr=100`, `decay_shift=0`. Weights 60 and 50 to neuron 3, then `step` → one spike with `idx=3`, `pot[3]=10`, `step_done` at step+9 cycles (NEURONS=8).
- **Reset-to-zero and refractory.** `reset_mode=1`, `REFRACT=2`. Weight 120 to neuron 0, then step → spike, `pot[0]=0`. Weight 200 to neuron 0 on each of the next two steps → both discarded, no spike. Third step with weight 200 → spike.
- **Leak.** `decay_shift=2`, `pot[5]=64`, `thr=1000` → after successive steps `pot[5]` is 48, then 36. With `pot = −64` → −48.
- **Backpressure.** Neurons 1 and 6 over threshold, `spike_ready` held low for 5 cycles → `spike_idx=1` stable for 5 cycles, then spikes 1 then 6 in order, `step_done` delayed by 5 cycles.
- **Saturation and bounds.**
  - `pot = 32760` plus weight 100 → 32767.
  - `pot = −32760` plus weight −100 → −32768.
  - Weight to `in_idx = 8` with NEURONS=8 → no state change.
- **Overrun and reset mid-scan.**
  - `step` during SCAN → `step_overrun` pulse, scan unaffected.
  - `reset` during a spike stall → next cycle `spike_valid=0`, all potentials 0, `in_ready=1`.
